// File: rtl/victim_cache_fa8.sv
// 8-entry fully associative victim cache for 512-bit blocks.
// Pipeline: PRE-TL capture, TL tag lookup and array commit, TV word select, DM output register.

module mux2_1 #(
    parameter int W = 1
) (
    input  logic [W-1:0] d0_i,
    input  logic [W-1:0] d1_i,
    input  logic         sel_i,
    output logic [W-1:0] y_o
);
    assign y_o = sel_i ? d1_i : d0_i;
endmodule

module mux8_1 #(
    parameter int W = 8
) (
    input  logic [8*W-1:0] d_i,
    input  logic [2:0]     sel_i,
    output logic [W-1:0]   y_o
);
    assign y_o = d_i[sel_i*W +: W];
endmodule

// Age-based 8-way tracker: age 0 is MRU, age 7 is LRU; ages stay a permutation of 0..7.
module lru (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       access_i,
    input  logic [2:0] way_i,
    output logic [2:0] lru_way_o
);
    logic [2:0] age_q [8];
    logic [2:0] age_d [8];
    logic [2:0] acc_age;

    always_comb begin
        lru_way_o = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (age_q[i] == 3'd7) begin
                lru_way_o = 3'(i);
            end
        end
    end

    always_comb begin
        acc_age = age_q[way_i];
        for (int i = 0; i < 8; i++) begin
            age_d[i] = age_q[i];
        end
        if (access_i) begin
            for (int i = 0; i < 8; i++) begin
                if (age_q[i] < acc_age) begin
                    age_d[i] = age_q[i] + 3'd1;
                end
            end
            age_d[way_i] = 3'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 8; i++) begin
                age_q[i] <= 3'(7 - i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end
endmodule

module victim_cache_fa8 (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [11:0]  page_offset_i,
    input  logic [511:0] data_in_i,
    input  logic         write_en_i,
    input  logic [43:0]  phys_tag_ret_i,
    input  logic         tlb_miss_i,
    output logic [7:0]   byte_out_o,
    output logic         is_found_o,
    output logic [511:0] block_out_o
);
    logic [11:0]  off_tl_q;
    logic [511:0] data_tl_q;
    logic         wr_tl_q;

    logic [49:0]  tag_q  [8];
    logic [511:0] data_q [8];
    logic [7:0]   valid_q;

    logic         found_tv_q;
    logic [511:0] block_tv_q;
    logic [5:0]   off_tv_q;

    logic [63:0]  word_dm_q;
    logic [2:0]   bs_dm_q;
    logic         found_dm_q;
    logic [511:0] block_dm_q;

    logic [49:0]  key;
    logic [7:0]   hit;
    logic         hit_any;
    logic [2:0]   hit_way;
    logic [2:0]   lru_way;
    logic [2:0]   target_way;
    logic         tlb_eff;
    logic         rd_found;
    logic         found_tl;
    logic         access;
    logic [511:0] block_tl;
    logic [63:0]  word_tv;

    assign key = {phys_tag_ret_i, off_tl_q[11:6]};

    always_comb begin
        hit     = '0;
        hit_any = 1'b0;
        hit_way = 3'd0;
        for (int w = 0; w < 8; w++) begin
            hit[w] = valid_q[w] && (tag_q[w] == key);
            if (hit[w]) begin
                hit_any = 1'b1;
                hit_way = 3'(w);
            end
        end
    end

    // Writes ignore the TLB miss flag.
    mux2_1 #(.W(1)) u_tlb_gate (
        .d0_i (tlb_miss_i),
        .d1_i (1'b0),
        .sel_i(wr_tl_q),
        .y_o  (tlb_eff)
    );

    assign rd_found = hit_any & ~tlb_eff;

    mux2_1 #(.W(1)) u_found_gate (
        .d0_i (1'b0),
        .d1_i (rd_found),
        .sel_i(~wr_tl_q),
        .y_o  (found_tl)
    );

    assign target_way = hit_any ? hit_way : lru_way;
    assign access     = wr_tl_q | found_tl;

    // Read hit returns the hit block; write returns the victim's old contents.
    mux2_1 #(.W(512)) u_block_gate (
        .d0_i ('0),
        .d1_i (data_q[target_way]),
        .sel_i(access),
        .y_o  (block_tl)
    );

    lru u_lru (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .access_i (access),
        .way_i    (target_way),
        .lru_way_o(lru_way)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            off_tl_q  <= '0;
            data_tl_q <= '0;
            wr_tl_q   <= 1'b0;
        end else begin
            off_tl_q  <= page_offset_i;
            data_tl_q <= data_in_i;
            wr_tl_q   <= write_en_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
            for (int w = 0; w < 8; w++) begin
                tag_q[w]  <= '0;
                data_q[w] <= '0;
            end
        end else if (wr_tl_q) begin
            valid_q[target_way] <= 1'b1;
            tag_q[target_way]   <= key;
            data_q[target_way]  <= data_tl_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            found_tv_q <= 1'b0;
            block_tv_q <= '0;
            off_tv_q   <= '0;
        end else begin
            found_tv_q <= found_tl;
            block_tv_q <= block_tl;
            off_tv_q   <= off_tl_q[5:0];
        end
    end

    mux8_1 #(.W(64)) u_word_sel (
        .d_i  (block_tv_q),
        .sel_i(off_tv_q[5:3]),
        .y_o  (word_tv)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            word_dm_q  <= '0;
            bs_dm_q    <= '0;
            found_dm_q <= 1'b0;
            block_dm_q <= '0;
        end else begin
            word_dm_q  <= word_tv;
            bs_dm_q    <= off_tv_q[2:0];
            found_dm_q <= found_tv_q;
            block_dm_q <= block_tv_q;
        end
    end

    mux8_1 #(.W(8)) u_byte_sel (
        .d_i  (word_dm_q),
        .sel_i(bs_dm_q),
        .y_o  (byte_out_o)
    );

    assign is_found_o  = found_dm_q;
    assign block_out_o = block_dm_q;
endmodule

// File: tb/tb_victim_cache_fa8.sv
// Directed bench for victim_cache_fa8: hit/miss, byte select, LRU eviction, pipelined
// write-then-read and asynchronous reset.

module tb_victim_cache_fa8;
    logic         clk;
    logic         rst_n;
    logic [11:0]  page_offset;
    logic [511:0] data_in;
    logic         write_en;
    logic [43:0]  phys_tag_ret;
    logic         tlb_miss;
    logic [7:0]   byte_out;
    logic         is_found;
    logic [511:0] block_out;

    int n_vec;
    int n_err;

    victim_cache_fa8 dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .page_offset_i (page_offset),
        .data_in_i     (data_in),
        .write_en_i    (write_en),
        .phys_tag_ret_i(phys_tag_ret),
        .tlb_miss_i    (tlb_miss),
        .byte_out_o    (byte_out),
        .is_found_o    (is_found),
        .block_out_o   (block_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one request and leave the clock at the negedge after its DM capture.
    task automatic req(input logic wr, input logic [43:0] pt, input logic [11:0] off,
                       input logic [511:0] d, input logic tm);
        @(negedge clk);
        page_offset = off;
        data_in     = d;
        write_en    = wr;
        @(negedge clk);
        phys_tag_ret = pt;
        tlb_miss     = tm;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [511:0] blk(input int i);
        logic [31:0] w;
        w = 32'h0101_0101 * 32'(i + 1);
        return {16{w}};
    endfunction

    function automatic logic [43:0] kt(input int i);
        return 44'h100 + 44'(i);
    endfunction

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        page_offset  = '0;
        data_in      = '0;
        write_en     = 1'b0;
        phys_tag_ret = '0;
        tlb_miss     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_found", 512'(is_found), 512'd0);
        chk("rst_byte", 512'(byte_out), 512'd0);
        chk("rst_block", block_out, 512'd0);
        rst_n = 1'b1;

        req(1'b1, 44'hA, 12'h000, 512'hAAA, 1'b0);
        chk("wrA_found", 512'(is_found), 512'd0);
        chk("wrA_evict", block_out, 512'd0);

        req(1'b0, 44'hA, 12'h000, '0, 1'b0);
        chk("rdA0_found", 512'(is_found), 512'd1);
        chk("rdA0_byte", 512'(byte_out), 512'hAA);
        chk("rdA0_block", block_out, 512'hAAA);
        req(1'b0, 44'hA, 12'h001, '0, 1'b0);
        chk("rdA1_byte", 512'(byte_out), 512'h0A);
        req(1'b0, 44'hA, 12'h008, '0, 1'b0);
        chk("rdA8_found", 512'(is_found), 512'd1);
        chk("rdA8_byte", 512'(byte_out), 512'h00);

        req(1'b0, 44'hA, 12'h000, '0, 1'b1);
        chk("tlbA_found", 512'(is_found), 512'd0);
        chk("tlbA_byte", 512'(byte_out), 512'd0);
        chk("tlbA_block", block_out, 512'd0);
        req(1'b0, 44'hB, 12'h000, '0, 1'b0);
        chk("rdB_found", 512'(is_found), 512'd0);
        chk("rdB_byte", 512'(byte_out), 512'd0);
        chk("rdB_block", block_out, 512'd0);

        do_reset();
        req(1'b0, 44'hA, 12'h000, '0, 1'b0);
        chk("postrst_rdA", 512'(is_found), 512'd0);

        for (int i = 0; i < 8; i++) begin
            req(1'b1, kt(i), 12'h000, blk(i), 1'b0);
            chk($sformatf("wrK%0d_evict", i), block_out, 512'd0);
        end
        req(1'b0, kt(0), 12'h000, '0, 1'b0);
        chk("rdK0_found", 512'(is_found), 512'd1);
        chk("rdK0_block", block_out, blk(0));
        req(1'b1, kt(8), 12'h000, blk(8), 1'b0);
        chk("wrK8_found", 512'(is_found), 512'd0);
        chk("wrK8_evict", block_out, blk(1));
        chk("wrK8_byte", 512'(byte_out), 512'h02);
        req(1'b0, kt(1), 12'h000, '0, 1'b0);
        chk("rdK1_miss", 512'(is_found), 512'd0);
        req(1'b0, kt(0), 12'h000, '0, 1'b0);
        chk("rdK0b_block", block_out, blk(0));
        req(1'b0, kt(8), 12'h000, '0, 1'b0);
        chk("rdK8_found", 512'(is_found), 512'd1);
        chk("rdK8_block", block_out, blk(8));

        req(1'b1, kt(9), 12'h000, blk(9), 1'b1);
        chk("wrK9_found", 512'(is_found), 512'd0);
        req(1'b0, kt(9), 12'h000, '0, 1'b0);
        chk("rdK9_found", 512'(is_found), 512'd1);
        chk("rdK9_block", block_out, blk(9));

        // Write K10 then read K10 in the very next cycle.
        @(negedge clk);
        page_offset = 12'h000;
        data_in     = blk(10);
        write_en    = 1'b1;
        @(negedge clk);
        phys_tag_ret = kt(10);
        tlb_miss     = 1'b0;
        write_en     = 1'b0;
        data_in      = '0;
        @(negedge clk);
        @(negedge clk);
        chk("pipe_wr_found", 512'(is_found), 512'd0);
        @(negedge clk);
        chk("pipe_rd_found", 512'(is_found), 512'd1);
        chk("pipe_rd_block", block_out, blk(10));

        #2 rst_n = 1'b0;
        #1;
        chk("midrst_found", 512'(is_found), 512'd0);
        chk("midrst_byte", 512'(byte_out), 512'd0);
        chk("midrst_block", block_out, 512'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req(1'b0, kt(0), 12'h000, '0, 1'b0);
        chk("midrst_rdK0", 512'(is_found), 512'd0);
        req(1'b0, kt(10), 12'h000, '0, 1'b0);
        chk("midrst_rdK10", 512'(is_found), 512'd0);
        chk("midrst_rdK10_blk", block_out, 512'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/victim_cache_fa8.md
Name: victim_cache_fa8

Overview:
- 8-entry fully associative victim cache holding 512-bit blocks. Entries are keyed by a 50-bit {physical tag, virtual index}.
- Sits beside the L1 data cache. Accepts one read or write per cycle in a 3-stage pipeline: PRE-TL, TL (tag lookup), TV (word select), then DM output register.
- Built from the codebase primitives mux2_1, mux8_1 and lru (8-way replacement tracker).

Parameters:
- None. Fixed constants: 8 ways, 512-bit block, 44-bit ptag, 6-bit vindex, 6-bit block offset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- page_offset  input  12  [11:6] vindex, [5:3] word select, [2:0] byte select
- data_in  input  512  block to insert on write
- write_en  input  1  1 = insert data_in, 0 = read lookup
- phys_tag_ret  input  44  TLB physical tag; valid one cycle after the request
- tlb_miss  input  1  TLB miss flag; valid one cycle after the request
- byte_out  output  8  selected byte
- is_found  output  1  read hit flag
- block_out  output  512  hit block on read; evicted block on write

Behaviour:
- Reset (async, active-low): all pipeline registers, tag/valid/data arrays and outputs clear to 0. LRU ages set to age[i]=7-i, so way 0 is LRU.
- Cycle E0 (rising edge): page_offset, data_in and write_en are registered.
- Cycle after E0 (TL stage):
  - key = {phys_tag_ret, registered vindex}.
  - hit[w] = valid[w] && tag[w]==key; at most one way hits.
- Read, with tlb_miss=0 and a hit:
  - Way w is selected and made MRU at E1.
- Read with a miss, or with tlb_miss=1:
  - No state change.
  - Downstream registers load is_found=0 and block=0.
- Write (tlb_miss is ignored and treated as 0):
  - Target way = hit way if the key is already present, else the LRU way (age 7).
  - At E1: old data of the target way is captured as the evicted block; tag, valid=1 and data are written; target becomes MRU.
- LRU update on an access to way w with age a: every way with age < a increments, age[w]=0. Ages remain a permutation of 0..7.
- E1 → E2: found flag, block, and offset pass through the TV stage.
  - TV selects 64-bit word = block[64*ws+63 : 64*ws], with ws = offset[5:3].
  - DM register captures the word, byte select, found flag and block.
- Outputs are driven combinationally from DM registers; they are valid after E2, i.e. 2 cycles after request capture.
  - byte_out = word[8*bs+7 : 8*bs], with bs = offset[2:0].
  - Read hit: is_found=1, block_out=hit block, byte_out=addressed byte.
  - Read miss or tlb_miss: is_found=0, block_out=0, byte_out=0x00.
  - Write: is_found=0, block_out=evicted block (0 if the way was never written), byte_out=addressed byte of the evicted block.
- Fully pipelined: a new request is accepted every cycle.
  - A read issued the cycle after a write to the same key sees that write, since the write commits at E1, before the read's TL stage.
- Reset asserted mid-operation clears all in-flight requests; outputs go to 0 immediately.
- Word and byte select use mux8_1; write/tlb gating uses mux2_1.

Test Plan:
- Reset low → is_found=0, byte_out=0x00, block_out=0.
- Write ptag=0xA, offset=0x000, data=0x...AAA → 2 cycles later is_found=0, block_out=0 (empty way 0 evicted).
- Read ptag=0xA:
  - offset=0x000 → is_found=1, byte_out=0xAA, block_out=0x...AAA.
  - offset=0x001 → byte_out=0x0A.
  - offset=0x008 → byte_out=0x00 (word 1).
- Same read with tlb_miss=1 → is_found=0, byte_out=0x00, block_out=0. A read of ptag=0xB (never written) → identical miss response.
- Eviction order:
  - Write 8 distinct keys K0..K7 with data D0..D7; read K0 (hit); write K8 → block_out=D1 (K1 evicted).
  - Subsequent read of K1 misses; reads of K0 and K8 hit.
- Write with tlb_miss=1 → write still committed; later read of that key hits.
- Reset pulsed mid-stream → outputs 0 and all prior entries miss.
